// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: run/stop/single-step controller for the single-cycle RV32 core.
// core_en gates PC load, register-file write and data-memory write so the core
// advances exactly one instruction per enabled cycle.
//
// Optional feature macro: DBG_BREAKPOINT_EN (PC breakpoint with skip-once resume).
// When undefined, bp_hit is 0, skip_bp does not exist, BREAK is unreachable and
// bp_addr/bp_valid are ignored.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   run_req       pulse: free-run
//   stop_req      pulse: stop after the current instruction
//   step_req      pulse: execute step_count instructions (0 treated as 1)
//   step_count    instructions per step
//   pc            current PC (ProgramCounter Q)
//   core_halt     halt opcode decoded for the instruction at pc
//   bp_addr       breakpoint address
//   bp_valid      breakpoint armed
//   core_en       combinational commit enable for the current instruction
//   state         encoded state: IDLE=0 RUN=1 STEP=2 BREAK=3 HALT=4
//   stop_cause    00 step done/none, 01 user stop, 10 breakpoint, 11 halt
//   retired       count of cycles with core_en=1 (wraps)
module debug_run_ctrl #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned STEP_W = 8,
    parameter int unsigned RET_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic [PC_W-1:0]   pc,
    input  logic              core_halt,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_valid,
    output logic              core_en,
    output logic [2:0]        state,
    output logic [1:0]        stop_cause,
    output logic [RET_W-1:0]  retired
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BREAK = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_USER = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_HALT = 2'b11;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_left_q, step_left_d;
    logic [1:0]        cause_q, cause_d;
    logic [RET_W-1:0]  retired_q;
    logic [STEP_W-1:0] step_load;
    logic              bp_hit_c;
    logic              core_en_c;
    logic              set_skip;
    logic              clr_skip;

    // Breakpoint match; skip_bp lets the instruction at bp_addr run once on resume.
`ifdef DBG_BREAKPOINT_EN
    logic skip_bp_q;

    assign bp_hit_c = bp_valid & (pc == bp_addr) & ~skip_bp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           skip_bp_q <= 1'b0;
        else if (set_skip) skip_bp_q <= 1'b1;
        else if (clr_skip) skip_bp_q <= 1'b0;
    end
`else
    logic unused_bp;

    assign bp_hit_c  = 1'b0;
    assign unused_bp = ^{bp_valid, bp_addr, set_skip, clr_skip};
`endif

    assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;

    // Same-cycle gating: a breakpointed or halting instruction never commits.
    assign core_en_c = ((state_q == ST_RUN) || (state_q == ST_STEP)) & ~core_halt & ~bp_hit_c;

    // State register and status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_left_q <= '0;
            cause_q     <= CAUSE_NONE;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            cause_q     <= cause_d;
            if (core_en_c) retired_q <= retired_q + RET_W'(1);
        end
    end

    // Next-state logic; exits from RUN/STEP: halt > breakpoint > stop > step done.
    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        cause_d     = cause_q;
        set_skip    = 1'b0;
        clr_skip    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_req) begin
                    state_d = ST_RUN;
                    cause_d = CAUSE_NONE;
                end else if (step_req) begin
                    state_d     = ST_STEP;
                    step_left_d = step_load;
                    cause_d     = CAUSE_NONE;
                end
            end
            ST_RUN, ST_STEP: begin
                if (core_halt) begin
                    state_d  = ST_HALT;
                    cause_d  = CAUSE_HALT;
                    clr_skip = 1'b1;
                end else if (bp_hit_c) begin
                    state_d  = ST_BREAK;
                    cause_d  = CAUSE_BP;
                    clr_skip = 1'b1;
                end else if (stop_req) begin
                    state_d  = ST_IDLE;
                    cause_d  = CAUSE_USER;
                    clr_skip = 1'b1;
                end else begin
                    // core_en is necessarily 1 here.
                    clr_skip = 1'b1;
                    if (state_q == ST_STEP) begin
                        step_left_d = step_left_q - STEP_W'(1);
                        if (step_left_q <= STEP_W'(1)) begin
                            state_d = ST_IDLE;
                            cause_d = CAUSE_NONE;
                        end
                    end
                end
            end
`ifdef DBG_BREAKPOINT_EN
            ST_BREAK: begin
                if (run_req) begin
                    state_d  = ST_RUN;
                    set_skip = 1'b1;
                end else if (step_req) begin
                    state_d     = ST_STEP;
                    step_left_d = step_load;
                    set_skip    = 1'b1;
                end
            end
`endif
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d  = ST_IDLE;
                clr_skip = 1'b1;
            end
        endcase
    end

    assign core_en    = core_en_c;
    assign state      = 3'(state_q);
    assign stop_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_debug_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, stop_req, step_req;
    logic [7:0]  step_count;
    logic [31:0] pc;
    logic        core_halt;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        core_en;
    logic [2:0]  state;
    logic [1:0]  stop_cause;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DBG_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    debug_run_ctrl #(.PC_W(32), .STEP_W(8), .RET_W(32)) dut (
        .clk(clk), .rst(rst),
        .run_req(run_req), .stop_req(stop_req), .step_req(step_req),
        .step_count(step_count), .pc(pc), .core_halt(core_halt),
        .bp_addr(bp_addr), .bp_valid(bp_valid),
        .core_en(core_en), .state(state), .stop_cause(stop_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic st, input logic [7:0] cnt,
                         input logic [31:0] p, input logic h);
        run_req = r; stop_req = s; step_req = st; step_count = cnt; pc = p; core_halt = h;
    endtask

    // Inputs change at posedge+1; checks happen at posedge+5.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'd0, 32'd0, 0);
        bp_valid = 1'b0; bp_addr = 32'd0;
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        run, stop, step;
        logic [7:0]  cnt;
        logic [31:0] pc;
        logic        halt;
        logic        en;
        logic [2:0]  st;
        logic [1:0]  ca;
        logic [31:0] ret;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic st, logic [7:0] c, logic [31:0] p,
                                logic h, logic e, logic [2:0] sta, logic [1:0] ca, logic [31:0] rt);
        vec_t v;
        v.run = r; v.stop = s; v.step = st; v.cnt = c; v.pc = p; v.halt = h;
        v.en = e; v.st = sta; v.ca = ca; v.ret = rt;
        return v;
    endfunction

    // Behavioural model: mode flags plus remaining-step count.
    bit          m_running, m_broken, m_halted, m_skip;
    int          m_steps;
    logic [1:0]  m_cause;
    logic [31:0] m_ret;

    task automatic m_reset();
        m_running = 0; m_broken = 0; m_halted = 0; m_skip = 0;
        m_steps = 0; m_cause = 2'b00; m_ret = 32'd0;
    endtask

    function automatic logic [2:0] m_state();
        if (m_halted) return 3'd4;
        if (m_broken) return 3'd3;
        if (m_running) return 3'd1;
        if (m_steps > 0) return 3'd2;
        return 3'd0;
    endfunction

    function automatic bit m_bp();
        return BP_EN && bp_valid && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_en();
        return (m_running || m_steps > 0) && !core_halt && !m_bp();
    endfunction

    task automatic m_edge();
        bit en, bp;
        int n;
        en = m_en();
        bp = m_bp();
        n  = (step_count == 8'd0) ? 1 : int'(step_count);
        if (en) m_ret = m_ret + 32'd1;
        if (m_halted) begin
            // sticky
        end else if (m_broken) begin
            if (run_req) begin
                m_broken = 0; m_running = 1; m_skip = 1;
            end else if (step_req) begin
                m_broken = 0; m_steps = n; m_skip = 1;
            end
        end else if (m_running || m_steps > 0) begin
            if (core_halt) begin
                m_halted = 1; m_running = 0; m_steps = 0; m_cause = 2'b11; m_skip = 0;
            end else if (bp) begin
                m_broken = 1; m_running = 0; m_steps = 0; m_cause = 2'b10; m_skip = 0;
            end else if (stop_req) begin
                m_running = 0; m_steps = 0; m_cause = 2'b01; m_skip = 0;
            end else begin
                m_skip = 0;
                if (m_steps > 0) begin
                    m_steps--;
                    if (m_steps == 0) m_cause = 2'b00;
                end
            end
        end else begin
            if (run_req) begin
                m_running = 1; m_cause = 2'b00;
            end else if (step_req) begin
                m_steps = n; m_cause = 2'b00;
            end
        end
    endtask

    vec_t vecs [21];

    initial begin
        int en_cnt;
        logic rr;

        vecs[0]  = mk(0,0,0,8'd0,32'h00,0, 0,3'd0,2'd0,32'd0);
        vecs[1]  = mk(1,0,0,8'd0,32'h00,0, 0,3'd0,2'd0,32'd0);
        vecs[2]  = mk(0,0,0,8'd0,32'h00,0, 1,3'd1,2'd0,32'd0);
        vecs[3]  = mk(0,0,0,8'd0,32'h04,0, 1,3'd1,2'd0,32'd1);
        vecs[4]  = mk(0,0,0,8'd0,32'h08,0, 1,3'd1,2'd0,32'd2);
        vecs[5]  = mk(0,1,0,8'd0,32'h0C,0, 1,3'd1,2'd0,32'd3);
        vecs[6]  = mk(0,0,0,8'd0,32'h10,0, 0,3'd0,2'd1,32'd4);
        vecs[7]  = mk(0,0,1,8'd3,32'h10,0, 0,3'd0,2'd1,32'd4);
        vecs[8]  = mk(0,0,0,8'd0,32'h10,0, 1,3'd2,2'd0,32'd4);
        vecs[9]  = mk(0,0,0,8'd0,32'h14,0, 1,3'd2,2'd0,32'd5);
        vecs[10] = mk(0,0,0,8'd0,32'h18,0, 1,3'd2,2'd0,32'd6);
        vecs[11] = mk(0,0,0,8'd0,32'h1C,0, 0,3'd0,2'd0,32'd7);
        vecs[12] = mk(0,0,1,8'd0,32'h1C,0, 0,3'd0,2'd0,32'd7);
        vecs[13] = mk(0,0,0,8'd0,32'h1C,0, 1,3'd2,2'd0,32'd7);
        vecs[14] = mk(0,0,0,8'd0,32'h20,0, 0,3'd0,2'd0,32'd8);
        vecs[15] = mk(1,0,0,8'd0,32'h20,0, 0,3'd0,2'd0,32'd8);
        vecs[16] = mk(0,0,0,8'd0,32'h20,0, 1,3'd1,2'd0,32'd8);
        vecs[17] = mk(0,0,0,8'd0,32'h24,1, 0,3'd1,2'd0,32'd9);
        vecs[18] = mk(1,0,0,8'd0,32'h24,1, 0,3'd4,2'd3,32'd9);
        vecs[19] = mk(0,0,1,8'd2,32'h24,0, 0,3'd4,2'd3,32'd9);
        vecs[20] = mk(0,1,0,8'd0,32'h24,0, 0,3'd4,2'd3,32'd9);

        rst = 1'b1;
        drive(0, 0, 0, 8'd0, 32'd0, 0);
        bp_valid = 1'b0; bp_addr = 32'd0;
        #3;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_en", 32'(core_en), 32'd0);
        chk("reset_cause", 32'(stop_cause), 32'd0);
        chk("reset_retired", retired, 32'd0);
        do_reset();

        // Table: run, stop, step N, step 0, halt stickiness.
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].run, vecs[i].stop, vecs[i].step, vecs[i].cnt, vecs[i].pc, vecs[i].halt);
            #4;
            chk($sformatf("vec%0d_en", i), 32'(core_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_cause", i), 32'(stop_cause), 32'(vecs[i].ca));
            chk($sformatf("vec%0d_retired", i), retired, vecs[i].ret);
            adv();
        end

        // Halt is left only by reset.
        rst = 1'b1;
        #2;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_retired", retired, 32'd0);
        do_reset();

        // Breakpoint with simultaneous stop, then skip-once step resume.
        bp_valid = 1'b1; bp_addr = 32'h10;
        drive(1, 0, 0, 8'd0, 32'h08, 0); #4; chk("bp_c1_en", 32'(core_en), 32'd0); adv();
        drive(0, 0, 0, 8'd0, 32'h08, 0); #4; chk("bp_c2_en", 32'(core_en), 32'd1); adv();
        drive(0, 0, 0, 8'd0, 32'h0C, 0); #4; chk("bp_c3_en", 32'(core_en), 32'd1); adv();
        drive(0, 1, 0, 8'd0, 32'h10, 0); #4;
        chk("bp_hit_en", 32'(core_en), BP_EN ? 32'd0 : 32'd1);
        adv();
        drive(0, 0, 0, 8'd0, 32'h10, 0); #4;
        chk("bp_state", 32'(state), BP_EN ? 32'd3 : 32'd0);
        chk("bp_cause", 32'(stop_cause), BP_EN ? 32'd2 : 32'd1);
        chk("bp_retired", retired, BP_EN ? 32'd2 : 32'd3);
        adv();
        drive(0, 0, 1, 8'd1, 32'h10, 0); #4; chk("bp_resume_en", 32'(core_en), 32'd0); adv();
        drive(0, 0, 0, 8'd0, 32'h10, 0); #4;
        chk("bp_skip_en", 32'(core_en), 32'd1);
        chk("bp_skip_state", 32'(state), 32'd2);
        adv();
        #4;
        chk("bp_done_state", 32'(state), 32'd0);
        chk("bp_done_cause", 32'(stop_cause), 32'd0);
        chk("bp_done_retired", retired, BP_EN ? 32'd3 : 32'd4);
        adv();
        drive(1, 0, 0, 8'd0, 32'h10, 0); adv();
        drive(0, 0, 0, 8'd0, 32'h10, 0); #4;
        chk("bp_rearm_en", 32'(core_en), BP_EN ? 32'd0 : 32'd1);
        adv();
        do_reset();

        // Async reset mid-step, then a fresh 2-instruction step.
        drive(0, 0, 1, 8'd7, 32'h0, 0); adv();
        drive(0, 0, 0, 8'd0, 32'h0, 0); adv();
        adv();
        #2;
        rst = 1'b1;
        #1;
        chk("midstep_rst_state", 32'(state), 32'd0);
        chk("midstep_rst_en", 32'(core_en), 32'd0);
        chk("midstep_rst_retired", retired, 32'd0);
        adv();
        rst = 1'b0;
        adv();
        drive(0, 0, 1, 8'd2, 32'h0, 0); adv();
        drive(0, 0, 0, 8'd0, 32'h0, 0);
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #4;
            if (core_en) en_cnt++;
            adv();
        end
        chk("step2_count", 32'(en_cnt), 32'd2);
        chk("step2_state", 32'(state), 32'd0);
        chk("step2_retired", retired, 32'd2);

        // Randomized run against the model.
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            rr         = ($urandom_range(0, 299) == 0);
            run_req    = ($urandom_range(0, 15) == 0);
            stop_req   = ($urandom_range(0, 31) == 0);
            step_req   = ($urandom_range(0, 11) == 0);
            step_count = 8'($urandom_range(0, 4));
            pc         = 32'(4 * $urandom_range(0, 7));
            core_halt  = ($urandom_range(0, 63) == 0);
            bp_valid   = 1'($urandom_range(0, 1));
            bp_addr    = 32'(4 * $urandom_range(0, 7));
            rst        = rr;
            if (rr) m_reset();
            #4;
            chk("rnd_en", 32'(core_en), 32'(m_en()));
            chk("rnd_state", 32'(state), 32'(m_state()));
            chk("rnd_cause", 32'(stop_cause), 32'(m_cause));
            chk("rnd_retired", retired, m_ret);
            @(posedge clk);
            if (!rr) m_edge();
            #1;
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
